// File: rtl/wash_pkg.sv
// Shared phase codes and status-LED bit positions for the wash sequencer.
package wash_pkg;

  // Phase codes; these values appear directly on the phase output.
  localparam logic [2:0] PH_IDLE  = 3'd0;
  localparam logic [2:0] PH_WASH  = 3'd1;
  localparam logic [2:0] PH_RINSE = 3'd2;
  localparam logic [2:0] PH_SPIN  = 3'd3;
  localparam logic [2:0] PH_PAUSE = 3'd4;
  localparam logic [2:0] PH_DONE  = 3'd5;

  // Status LED bit positions.
  localparam int LED_IDLE  = 0;
  localparam int LED_WASH  = 1;
  localparam int LED_RINSE = 2;
  localparam int LED_SPIN  = 3;
  localparam int LED_PAUSE = 4;
  localparam int LED_DONE  = 5;
  localparam int LED_FINE  = 6;
  localparam int LED_ERR   = 7;

  // One-hot phase indication for the low six LEDs.
  function automatic logic [7:0] led_onehot(input logic [2:0] ph);
    logic [7:0] l;
    l = 8'b0;
    case (ph)
      PH_IDLE:  l[LED_IDLE]  = 1'b1;
      PH_WASH:  l[LED_WASH]  = 1'b1;
      PH_RINSE: l[LED_RINSE] = 1'b1;
      PH_SPIN:  l[LED_SPIN]  = 1'b1;
      PH_PAUSE: l[LED_PAUSE] = 1'b1;
      PH_DONE:  l[LED_DONE]  = 1'b1;
      default:  l[LED_IDLE]  = 1'b1;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/wash_seq_sec_tick.sv
// One-second tick divider. Counts 0..TICK_DIV-1 while enabled and flags the
// wrap cycle. A load port lets the sequencer restore a saved sub-second
// position after a pause, while the pause itself reuses the same divider.
module sec_tick #(
  parameter int TICK_DIV = 100000000,
  parameter int CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] cnt,
  output logic          tick
);

  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  // Tick does not depend on clr/load so the FSM can use it to decide them.
  assign tick = en && (cnt == LAST);

  // Divider register: clear beats load beats count.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wash_seq.sv
// Wash-cycle sequencer: charges the balance on start, then runs
// WASH -> RINSE xN -> SPIN with per-second countdowns, pause/resume,
// abort and a one-shot fine for over-long pauses.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | waiting for start_p; refuses start when balance too low
//   WASH  | wash countdown, length from the selected program
//   RINSE | rinse countdown, repeated per program rinse count
//   SPIN  | spin countdown, only when dry_en was latched
//   PAUSE | phase timer frozen; pause seconds counted toward fine
//   DONE  | one-cycle completion, then IDLE
module wash_seq
  import wash_pkg::*;
#(
  parameter int TICK_DIV  = 100000000,
  parameter int NMODES    = 4,
  parameter int TW        = 10,
  parameter int BW        = 12,
  parameter int RINSE_S   = 30,
  parameter int SPIN_S    = 60,
  parameter int DRY_PRICE = 5,
  parameter int PAUSE_MAX = 120,
  parameter int FINE      = 10,
  parameter int MW        = (NMODES > 1) ? $clog2(NMODES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_p,
  input  logic                 pause_p,
  input  logic                 abort_p,
  input  logic [MW-1:0]        mode_sel,
  input  logic                 dry_en,
  input  logic signed [BW-1:0] bal_in,
  input  logic [NMODES*9-1:0]  mode_price,
  input  logic [NMODES*TW-1:0] mode_time,
  input  logic [NMODES*2-1:0]  mode_rinse,
  output logic                 busy,
  output logic [2:0]           phase,
  output logic [TW-1:0]        sec_left,
  output logic signed [BW-1:0] bal_out,
  output logic                 fine,
  output logic                 err_insuf,
  output logic                 done,
  output logic                 aborted,
  output logic [7:0]           st_light
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PW = (PAUSE_MAX > 0) ? $clog2(PAUSE_MAX + 1) : 1;
  localparam logic [PW-1:0] PMAX_C = PW'(PAUSE_MAX);

  logic [2:0]           state, state_n;
  logic [2:0]           saved_ph, saved_n;
  logic [1:0]           rinse_left, rinse_n, rinse_dec;
  logic                 dry_q, dry_n;
  logic [TW-1:0]        sec_n;
  logic signed [BW-1:0] bal_n;
  logic                 fine_n, err_n, done_n, abort_n, busy_n;
  logic [7:0]           light_n;
  logic [PW-1:0]        pause_cnt, pcnt_n;
  logic [CW-1:0]        saved_div, sdiv_n;

  logic                 div_en, div_clr, div_load, div_tick;
  logic [CW-1:0]        div_cnt;

  logic [8:0]           price_sel;
  logic [TW-1:0]        time_sel;
  logic [1:0]           rinse_sel;
  logic [BW-1:0]        cost;
  logic                 afford;
  logic [2:0]           follow;
  logic [TW-1:0]        follow_sec;

  assign phase = state;

  sec_tick #(
    .TICK_DIV (TICK_DIV),
    .CW       (CW)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .en       (div_en),
    .clr      (div_clr),
    .load     (div_load),
    .load_val (saved_div),
    .cnt      (div_cnt),
    .tick     (div_tick)
  );

  // Program lookup and affordability for the currently selected mode.
  always_comb begin
    price_sel = mode_price[9*int'(mode_sel) +: 9];
    time_sel  = mode_time[TW*int'(mode_sel) +: TW];
    rinse_sel = mode_rinse[2*int'(mode_sel) +: 2];
    cost      = BW'(price_sel) + (dry_en ? BW'(DRY_PRICE) : '0);
    afford    = (bal_in >= $signed(cost));
  end

  // Phase that follows the one currently ending, and its load value.
  always_comb begin
    rinse_dec  = rinse_left - 2'd1;
    follow     = PH_DONE;
    follow_sec = '0;
    if (state == PH_WASH) begin
      if (rinse_left != 2'd0) follow = PH_RINSE;
      else if (dry_q)         follow = PH_SPIN;
    end else if (state == PH_RINSE) begin
      if (rinse_dec != 2'd0)  follow = PH_RINSE;
      else if (dry_q)         follow = PH_SPIN;
    end
    case (follow)
      PH_RINSE: follow_sec = TW'(RINSE_S);
      PH_SPIN:  follow_sec = TW'(SPIN_S);
      default:  follow_sec = '0;
    endcase
  end

  // Next-state and next-output computation; abort > pause > tick.
  always_comb begin
    state_n  = state;
    saved_n  = saved_ph;
    rinse_n  = rinse_left;
    dry_n    = dry_q;
    sec_n    = sec_left;
    bal_n    = bal_out;
    fine_n   = fine;
    err_n    = err_insuf;
    abort_n  = 1'b0;
    pcnt_n   = pause_cnt;
    sdiv_n   = saved_div;
    div_en   = 1'b0;
    div_clr  = 1'b0;
    div_load = 1'b0;

    case (state)
      PH_IDLE: begin
        if (start_p) begin
          if (afford) begin
            bal_n   = bal_in - $signed(cost);
            err_n   = 1'b0;
            fine_n  = 1'b0;
            dry_n   = dry_en;
            rinse_n = rinse_sel;
            sec_n   = time_sel;
            state_n = PH_WASH;
            div_clr = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      end

      PH_WASH, PH_RINSE, PH_SPIN: begin
        if (abort_p) begin
          state_n = PH_IDLE;
          abort_n = 1'b1;
          sec_n   = '0;
          div_clr = 1'b1;
        end else if (pause_p) begin
          // Keep the sub-second position; the divider then times the pause.
          state_n = PH_PAUSE;
          saved_n = state;
          pcnt_n  = '0;
          sdiv_n  = div_cnt;
          div_clr = 1'b1;
        end else begin
          div_en = 1'b1;
          if (sec_left == '0 || (div_tick && sec_left == TW'(1))) begin
            state_n = follow;
            sec_n   = follow_sec;
            div_clr = 1'b1;
            if (state == PH_RINSE) rinse_n = rinse_dec;
          end else if (div_tick) begin
            sec_n = sec_left - TW'(1);
          end
        end
      end

      PH_PAUSE: begin
        if (abort_p) begin
          state_n = PH_IDLE;
          abort_n = 1'b1;
          sec_n   = '0;
          div_clr = 1'b1;
        end else if (pause_p) begin
          state_n  = saved_ph;
          div_load = 1'b1;
        end else begin
          div_en = 1'b1;
          if (div_tick && pause_cnt != PMAX_C) begin
            pcnt_n = pause_cnt + 1'b1;
            if (pcnt_n == PMAX_C && !fine) begin
              fine_n = 1'b1;
              bal_n  = bal_out - $signed(BW'(FINE));
            end
          end
        end
      end

      PH_DONE: begin
        state_n = PH_IDLE;
        abort_n = abort_p;
      end

      default: state_n = PH_IDLE;
    endcase

    done_n  = (state_n == PH_DONE);
    busy_n  = (state_n != PH_IDLE);
    light_n = led_onehot(state_n);
    light_n[LED_FINE] = fine_n;
    light_n[LED_ERR]  = err_n;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PH_IDLE;
      saved_ph   <= PH_IDLE;
      rinse_left <= '0;
      dry_q      <= 1'b0;
      sec_left   <= '0;
      bal_out    <= '0;
      fine       <= 1'b0;
      err_insuf  <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      busy       <= 1'b0;
      st_light   <= 8'b0000_0001;
      pause_cnt  <= '0;
      saved_div  <= '0;
    end else begin
      state      <= state_n;
      saved_ph   <= saved_n;
      rinse_left <= rinse_n;
      dry_q      <= dry_n;
      sec_left   <= sec_n;
      bal_out    <= bal_n;
      fine       <= fine_n;
      err_insuf  <= err_n;
      done       <= done_n;
      aborted    <= abort_n;
      busy       <= busy_n;
      st_light   <= light_n;
      pause_cnt  <= pcnt_n;
      saved_div  <= sdiv_n;
    end
  end

endmodule

// File: doc/wash_seq.md
Name: wash_seq

Overview:
- Parametrised wash-cycle sequencer; next generation of the washer controller.
- Takes debounced 1-cycle button pulses plus a programmed mode, charges the user balance, then steps WASH -> RINSE xN -> SPIN with per-second countdowns.
- Adds pause/resume, abort, and an over-long-pause fine; feeds the display and status-LED mux in the top level.

Parameters:
TICK_DIV, 100000000, clk cycles per one-second tick
NMODES, 4, number of selectable programs
TW, 10, width of seconds counters
BW, 12, signed balance width
RINSE_S, 30, seconds per rinse
SPIN_S, 60, spin seconds
DRY_PRICE, 5, extra charge when dry_en
PAUSE_MAX, 120, pause seconds before fine
FINE, 10, fine amount

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start_p  in  1  start pulse (middle button)
pause_p  in  1  pause/resume toggle pulse
abort_p  in  1  abort pulse
mode_sel  in  $clog2(NMODES)  program index
dry_en  in  1  include spin phase
bal_in  in  BW signed  balance presented at start
mode_price  in  NMODES*9  flat price table, entry i at [9i+8:9i]
mode_time  in  NMODES*TW  wash seconds per mode
mode_rinse  in  NMODES*2  rinse count per mode (0-3)
busy  out  1  not IDLE
phase  out  3  encoded current state
sec_left  out  TW  seconds remaining in phase
bal_out  out  BW signed  balance after charge/fine
fine  out  1  fine applied this cycle run
err_insuf  out  1  last start refused, insufficient balance
done  out  1  1-cycle completion pulse
aborted  out  1  1-cycle abort pulse
st_light  out  8  status LEDs

Behaviour:
- Reset (rst=1 at posedge clk): state IDLE; busy, fine, err_insuf, done, aborted = 0; sec_left = 0; bal_out = 0; st_light = 8'b0000_0001; tick counter = 0. Reset mid-cycle discards the run and issues no refund.
- States: IDLE, WASH, RINSE, SPIN, PAUSE, DONE.
- Tick: divider counts 0..TICK_DIV-1 only in WASH/RINSE/SPIN/PAUSE. Tick asserts on wrap. Cleared on every phase entry. Frozen (value held) in PAUSE for the phase timer; a separate pause-seconds counter uses the same tick.
- IDLE + start_p:
  - Latch mode_sel, dry_en, and rinse count.
  - cost = price[mode] + (dry_en ? DRY_PRICE : 0), zero-extended to BW.
  - If bal_in >= cost: bal_out <= bal_in - cost, err_insuf <= 0, fine <= 0, next cycle WASH.
  - Else: err_insuf <= 1, stay IDLE. err_insuf clears on the next accepted start or reset.
- Phase entry loads sec_left: WASH = mode_time[mode]; RINSE = RINSE_S; SPIN = SPIN_S.
- Timer: on tick, sec_left decrements. Tick with sec_left==1 ends the phase in that cycle. A phase loaded with 0 is skipped after one cycle.
- Phase order:
  - WASH -> RINSE if rinses > 0, else SPIN if dry_en, else DONE.
  - RINSE repeats `rinses` times; remaining-rinse counter decrements on each RINSE exit. Then SPIN if dry_en, else DONE.
  - SPIN -> DONE.
- DONE: done=1 for exactly one cycle, then IDLE. bal_out holds.
- PAUSE:
  - pause_p in WASH/RINSE/SPIN -> PAUSE; save phase; sec_left and divider hold.
  - pause_p in PAUSE -> return to saved phase with timers intact. No phase reload.
  - Pause counter clears on each PAUSE entry. When it reaches PAUSE_MAX, apply bal_out <= bal_out - FINE once per run and set fine=1. Stay paused.
- Abort: abort_p in any non-IDLE state -> IDLE next cycle, aborted=1 for one cycle, no refund, fine kept.
- Priority in one cycle: abort_p > pause_p > tick. start_p, pause_p, and abort_p are ignored in IDLE except start_p.
- bal_out is signed and may go negative after a fine. Arithmetic is signed BW, no saturation.
- st_light: [0]IDLE [1]WASH [2]RINSE [3]SPIN [4]PAUSE [5]DONE [6]fine [7]err_insuf. Bits 0-5 are one-hot.
- All outputs are registered.

Decomposition:
- Package wash_pkg: state enum with 3-bit phase codes (IDLE=0, WASH=1, RINSE=2, SPIN=3, PAUSE=4, DONE=5) and st_light bit-index constants.
- One sub-module sec_tick: divider with en/clr inputs and a tick output, parameter TICK_DIV. Instantiated once; the pause counter reuses its tick.

Test Plan (TICK_DIV=4, mode0 price 20, time 3, rinse 1, RINSE_S=2, SPIN_S=2):
- bal_in=50, dry_en=1, start_p -> bal_out=25. Phases WASH(3s) -> RINSE(2s) -> SPIN(2s); done pulses at cycle 1+4*7 (±1 entry cycle) after start.
- bal_in=10, start_p -> err_insuf=1, state IDLE, bal_out unchanged. Then bal_in=30 and start_p -> err_insuf=0, WASH.
- pause_p at WASH sec_left=2 and divider=1, hold 20 cycles, pause_p -> resumes at sec_left=2 and divider=1. Total run lengthened by exactly the paused cycles.
- PAUSE_MAX=2, pause for 3 s -> fine=1, bal_out decremented by FINE exactly once, st_light[6]=1.
- abort_p and pause_p in the same cycle during RINSE -> IDLE, aborted=1 for one cycle, no done.
- rst=1 mid-SPIN -> next cycle all outputs at reset values, st_light=8'b0000_0001.
